// File: rtl/shuff_stream_pkg.sv
// Shared defaults and elaboration helpers for the shuff_stream slice.
package shuff_stream_pkg;

    localparam int unsigned DefStride  = 29;
    localparam int unsigned DefRotStep = 1;
    localparam logic [63:0] DefInvKey  = 64'hA5C3_96E1_5A3C_691E;
    localparam int unsigned LaneW      = 32;

    function automatic int unsigned gcd(input int unsigned a, input int unsigned b);
        int unsigned x;
        int unsigned y;
        int unsigned t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic bit is_coprime(input int unsigned a, input int unsigned b);
        return gcd(a, b) == 1;
    endfunction

endpackage

// File: rtl/shuff_map.sv
// Combinational permutation: out[n] = word[(STRIDE*n + r) mod IN_W] ^ INV_KEY[n mod 64].
module shuff_map
    import shuff_stream_pkg::*;
#(
    parameter int unsigned IN_W    = 63,
    parameter int unsigned OUT_W   = 512,
    parameter int unsigned STRIDE  = DefStride,
    parameter logic [63:0] INV_KEY = DefInvKey,
    localparam int unsigned RW     = $clog2(IN_W)
) (
    input  logic [IN_W-1:0]  word,
    input  logic [RW-1:0]    r,
    output logic [OUT_W-1:0] mapped
);

    localparam logic [RW:0] Limit = (RW + 1)'(IN_W);

    for (genvar n = 0; n < OUT_W; n++) begin : g_bit
        // Static part of the index folds to a constant; only +r needs hardware.
        localparam logic [RW:0] Base = (RW + 1)'((STRIDE * n) % IN_W);

        logic [RW:0]   sum;
        logic [RW-1:0] idx;

        assign sum       = {1'b0, r} + Base;
        assign idx       = (sum >= Limit) ? RW'(sum - Limit) : sum[RW-1:0];
        assign mapped[n] = word[idx] ^ INV_KEY[n % 64];
    end

endmodule

// File: rtl/shuff_stream.sv
// Two-stage elastic shuffle: stage 1 captures word and rotation, stage 2 holds the mapped bus.
module shuff_stream
    import shuff_stream_pkg::*;
#(
    parameter int unsigned IN_W     = 63,
    parameter int unsigned OUT_W    = 512,
    parameter int unsigned STRIDE   = DefStride,
    parameter int unsigned ROT_STEP = DefRotStep,
    parameter logic [63:0] INV_KEY  = DefInvKey
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             mode,
    input  logic             rot_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [31:0]      words_out
);

    localparam int unsigned RW    = $clog2(IN_W);
    localparam logic [RW:0] Limit = (RW + 1)'(IN_W);
    localparam logic [RW:0] StepW = (RW + 1)'(ROT_STEP);

    if (IN_W < 2) begin : g_chk_in_w
        $error("shuff_stream: IN_W must be at least 2");
    end
    if ((OUT_W % LaneW) != 0) begin : g_chk_out_w
        $error("shuff_stream: OUT_W must be a multiple of 32");
    end
    if (!is_coprime(STRIDE, IN_W)) begin : g_chk_stride
        $error("shuff_stream: STRIDE must be coprime with IN_W");
    end
    if (ROT_STEP == 0 || ROT_STEP >= IN_W) begin : g_chk_rot_step
        $error("shuff_stream: ROT_STEP must satisfy 0 < ROT_STEP < IN_W");
    end

    logic             s1_valid;
    logic [IN_W-1:0]  s1_data;
    logic [RW-1:0]    s1_rot;
    logic [RW-1:0]    rot;
    logic [RW-1:0]    rot_sel;
    logic [RW-1:0]    rot_inc;
    logic [RW-1:0]    rot_next;
    logic [RW:0]      rot_sum;
    logic             s2_load;
    logic             accept;
    logic [OUT_W-1:0] mapped;

    assign s2_load  = !out_valid | out_ready;
    assign in_ready = !s1_valid | s2_load;
    assign accept   = in_valid & in_ready;

    assign rot_sel = (rot_clr | !mode) ? '0 : rot;
    assign rot_sum = {1'b0, rot} + StepW;
    assign rot_inc = (rot_sum >= Limit) ? RW'(rot_sum - Limit) : rot_sum[RW-1:0];

    always_comb begin
        rot_next = rot;
        if (mode) begin
            rot_next = rot_clr ? RW'(ROT_STEP) : rot_inc;
        end else if (rot_clr) begin
            rot_next = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_rot   <= '0;
            rot      <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_data  <= in_data;
            s1_rot   <= rot_sel;
            rot      <= rot_next;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    shuff_map #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .STRIDE  (STRIDE),
        .INV_KEY (INV_KEY)
    ) u_map (
        .word   (s1_data),
        .r      (s1_rot),
        .mapped (mapped)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= mapped;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            words_out <= '0;
        end else if (out_valid && out_ready) begin
            words_out <= words_out + 32'd1;
        end
    end

endmodule

// File: tb/tb_shuff_stream.sv
// Directed plus randomized bench for shuff_stream against a queue-based reference model.
module tb_shuff_stream;

    localparam int unsigned IN_W     = 63;
    localparam int unsigned OUT_W    = 512;
    localparam int unsigned STRIDE   = 29;
    localparam int unsigned ROT_STEP = 1;
    localparam logic [63:0] KEY      = 64'hA5C3_96E1_5A3C_691E;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_data = '0;
    logic             mode = 1'b0;
    logic             rot_clr = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_data;
    logic [31:0]      words_out;

    shuff_stream #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .STRIDE   (STRIDE),
        .ROT_STEP (ROT_STEP),
        .INV_KEY  (KEY)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mode      (mode),
        .rot_clr   (rot_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .words_out (words_out)
    );

    always #5 clk = ~clk;

    int               n_checks = 0;
    int               n_pass = 0;
    logic [OUT_W-1:0] exp_q[$];
    int               rot_m = 0;
    int               n_deliv = 0;
    int               n_acc = 0;
    logic             hold_pending = 1'b0;
    logic [OUT_W-1:0] hold_data = '0;

    task automatic check(input string tag, input logic [OUT_W-1:0] obs,
                         input logic [OUT_W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference mapping straight from the arithmetic definition.
    function automatic logic [OUT_W-1:0] ref_map(input logic [IN_W-1:0] d, input int r);
        logic [63:0]      key;
        logic [OUT_W-1:0] res;
        key = KEY;
        for (int n = 0; n < OUT_W; n++) begin
            res[n] = d[(STRIDE * n + r) % IN_W] ^ key[n % 64];
        end
        return res;
    endfunction

    function automatic logic [IN_W-1:0] rand_word();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[IN_W-1:0];
    endfunction

    function automatic logic [OUT_W-1:0] pattern(input int bits[$]);
        logic [OUT_W-1:0] p;
        p = '0;
        foreach (bits[i]) p[bits[i]] = 1'b1;
        return p;
    endfunction

    // One clock: drive at negedge, sample and score before the posedge.
    task automatic step(input logic v, input logic [IN_W-1:0] d, input logic m,
                        input logic clr, input logic ordy);
        int r;
        in_valid  = v;
        in_data   = d;
        mode      = m;
        rot_clr   = clr;
        out_ready = ordy;
        #1;
        check("in_ready", in_ready, (exp_q.size() < 2) || ordy);
        check("words_out", words_out, n_deliv);
        if (exp_q.size() == 0) check("idle_out_valid", out_valid, 0);
        if (hold_pending) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, hold_data);
        end
        if (out_valid && ordy) begin
            check("deliver_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("out_data", out_data, exp_q.pop_front());
            n_deliv++;
        end
        hold_pending = out_valid & !ordy;
        hold_data    = out_data;
        if (v && in_ready) begin
            r = clr ? 0 : (m ? rot_m : 0);
            exp_q.push_back(ref_map(d, r));
            if (m) rot_m = clr ? ROT_STEP : (rot_m + ROT_STEP) % IN_W;
            else if (clr) rot_m = 0;
            n_acc++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(0, '0, 0, 0, 1);
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OUT_W-1:0] pat0;
        logic [OUT_W-1:0] pat1;
        logic [OUT_W-1:0] keyrep;
        int               acc0;

        pat0   = pattern('{0, 63, 126, 189, 252, 315, 378, 441, 504});
        pat1   = pattern('{13, 76, 139, 202, 265, 328, 391, 454});
        keyrep = {8{KEY}};

        // Reset state.
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_words_out", words_out, 0);
        check("rst_out_data", out_data, '0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Static map, single word, 2-cycle latency.
        step(1, 63'h1, 0, 0, 1);
        check("lat_c1_valid", out_valid, 0);
        step(0, '0, 0, 0, 1);
        check("lat_c2_valid", out_valid, 1);
        check("static_r0_bits", out_data ^ keyrep, pat0);
        step(0, '0, 0, 0, 1);
        check("words_out_one", words_out, 1);

        // Rotating map, back-to-back, consecutive outputs.
        step(1, 63'h1, 1, 0, 1);
        step(1, 63'h1, 1, 0, 1);
        check("rot_w1_valid", out_valid, 1);
        check("rot_w1_bits", out_data ^ keyrep, pat0);
        step(0, '0, 0, 0, 1);
        check("rot_w2_valid", out_valid, 1);
        check("rot_w2_bits", out_data ^ keyrep, pat1);
        step(0, '0, 0, 0, 1);
        drain();

        // Rotation wrap: clear, 62 more, then clear again on the 64th.
        step(1, rand_word(), 1, 1, 1);
        for (int i = 0; i < 62; i++) step(1, rand_word(), 1, 0, 1);
        step(1, rand_word(), 1, 1, 1);
        step(1, rand_word(), 1, 0, 1);
        drain();

        // Inversion key alone.
        step(1, '0, 0, 0, 0);
        step(0, '0, 0, 0, 0);
        check("key_valid", out_valid, 1);
        check("key_low64", out_data[63:0], 64'hA5C3_96E1_5A3C_691E);
        check("key_full", out_data, keyrep);
        drain();

        // Backpressure: 5 cycles stalled with distinct words offered.
        acc0 = n_acc;
        for (int i = 0; i < 5; i++) step(1, IN_W'(64'h100 + i), 0, 0, 0);
        check("stall_accepts", n_acc - acc0, 2);
        check("stall_in_ready", in_ready, 0);
        drain();

        // Asynchronous reset with both stages full.
        step(1, rand_word(), 1, 0, 0);
        step(1, rand_word(), 1, 0, 0);
        step(1, rand_word(), 1, 0, 0);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_words_out", words_out, 0);
        check("arst_in_ready", in_ready, 1);
        exp_q.delete();
        rot_m        = 0;
        n_deliv      = 0;
        hold_pending = 1'b0;
        in_valid     = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        step(1, rand_word(), 1, 0, 1);
        step(1, rand_word(), 1, 0, 1);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, rand_word(), $urandom % 2, ($urandom % 8) == 0,
                 ($urandom % 4) != 0);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
